// File: rtl/imm_encoder.sv
// RV32I instruction assembler: packs decoded fields and a full immediate into I/S/B/U/J words,
// and expands the LI pseudo-op into ADDI, LUI, or a LUI+ADDI pair.
module imm_encoder #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam logic [2:0] FmtI  = 3'd0;
  localparam logic [2:0] FmtS  = 3'd1;
  localparam logic [2:0] FmtB  = 3'd2;
  localparam logic [2:0] FmtU  = 3'd3;
  localparam logic [2:0] FmtJ  = 3'd4;
  localparam logic [2:0] FmtLi = 3'd5;

  localparam logic [6:0] OpLui  = 7'h37;
  localparam logic [6:0] OpAddi = 7'h13;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  typedef enum logic [0:0] {StIdle, StLiLo} state_e;

  state_e                 state_q;
  logic                   out_valid_q;
  logic                   out_err_q;
  logic [31:0]            out_instr_q;
  logic [31:0]            li_lo_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  logic                   fits_12;
  logic                   fits_13;
  logic                   fits_21;
  logic [19:0]            li_hi;
  logic [31:0]            li_addi_word;
  logic [31:0]            enc_word;
  logic                   enc_err;
  logic                   li_two;
  logic                   in_fire;
  logic                   out_fire;

  always_comb begin
    // Signed range tests: the value fits when all bits above the field's sign bit agree.
    fits_12 = (in_imm[31:11] == {21{in_imm[11]}});
    fits_13 = (in_imm[31:12] == {20{in_imm[12]}});
    fits_21 = (in_imm[31:20] == {12{in_imm[20]}});
    // (imm + 0x800)[31:12] compensates for the sign-extended ADDI low part; wraps mod 2^20.
    li_hi        = in_imm[31:12] + {19'd0, in_imm[11]};
    li_addi_word = {in_imm[11:0], in_rd, 3'b000, in_rd, OpAddi};

    enc_word = Nop;
    enc_err  = 1'b0;
    li_two   = 1'b0;
    case (in_fmt)
      FmtI: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = !fits_12;
      end
      FmtS: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = !fits_12;
      end
      FmtB: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], in_opcode};
        enc_err  = !fits_13 || in_imm[0];
      end
      FmtU: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = (in_imm[11:0] != 12'd0);
      end
      FmtJ: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = !fits_21 || in_imm[0];
      end
      FmtLi: begin
        if (fits_12) begin
          enc_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, OpAddi};
        end else begin
          enc_word = {li_hi, in_rd, OpLui};
          li_two   = (in_imm[11:0] != 12'd0);
        end
      end
      default: begin
        enc_word = Nop;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_err_q   <= 1'b0;
      li_lo_q     <= 32'd0;
      err_cnt_q   <= '0;
    end else begin
      if (out_fire && out_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
      case (state_q)
        StIdle: begin
          if (in_fire) begin
            out_valid_q <= 1'b1;
            out_instr_q <= enc_word;
            out_err_q   <= enc_err;
            if (li_two) begin
              li_lo_q <= li_addi_word;
              state_q <= StLiLo;
            end
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
          end
        end
        StLiLo: begin
          // LUI word leaves; ADDI word takes its place with no bubble.
          if (out_fire) begin
            out_instr_q <= li_lo_q;
            out_err_q   <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != StIdle) || out_valid_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: vector table plus scoreboard, with hand sequences for LI backpressure,
// throughput, random backpressure and reset during a pending LI second word.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic        busy;

  always #5 clk = ~clk;

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        e;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_errcnt = 0;
  int          stall_cnt = 0;
  int          out_run = 0;
  int          max_run = 0;
  int          rdy_mode = 0;
  logic        rdy_man = 1'b1;
  int          pend_n = 0;
  logic [31:0] pend_w0, pend_w1;
  logic        pend_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;
  vec_t        tbl[17];

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm, input int n, input logic [31:0] w0,
                              input logic [31:0] w1, input logic e);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.imm = imm;
    v.n = n; v.w0 = w0; v.w1 = w1; v.e = e;
    return v;
  endfunction

  // Reference encoder working from signed arithmetic ranges.
  task automatic model(inout vec_t v);
    longint      s;
    logic [31:0] t;
    s = longint'($signed(v.imm));
    v.n = 1; v.w1 = 32'd0; v.e = 1'b0;
    case (v.fmt)
      3'd0: begin
        v.w0 = {v.imm[11:0], v.rs1, v.f3, v.rd, v.op};
        v.e  = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        v.w0 = {v.imm[11:5], v.rs2, v.rs1, v.f3, v.imm[4:0], v.op};
        v.e  = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        v.w0 = {v.imm[12], v.imm[10:5], v.rs2, v.rs1, v.f3, v.imm[4:1], v.imm[11], v.op};
        v.e  = (s < -4096) || (s > 4094) || v.imm[0];
      end
      3'd3: begin
        v.w0 = {v.imm[31:12], v.rd, v.op};
        v.e  = (v.imm[11:0] != 12'd0);
      end
      3'd4: begin
        v.w0 = {v.imm[20], v.imm[10:1], v.imm[11], v.imm[19:12], v.rd, v.op};
        v.e  = (s < -1048576) || (s > 1048574) || v.imm[0];
      end
      3'd5: begin
        t = v.imm + 32'h800;
        if (s >= -2048 && s <= 2047) begin
          v.w0 = {v.imm[11:0], 5'd0, 3'd0, v.rd, 7'h13};
        end else if (v.imm[11:0] == 12'd0) begin
          v.w0 = {v.imm[31:12], v.rd, 7'h37};
        end else begin
          v.n  = 2;
          v.w0 = {t[31:12], v.rd, 7'h37};
          v.w1 = {v.imm[11:0], v.rd, 3'd0, v.rd, 7'h13};
        end
      end
      default: begin
        v.w0 = 32'h0000_0013;
        v.e  = 1'b1;
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = rdy_man;
    endcase
  endtask

  task automatic drive(input vec_t v);
    pend_n = v.n; pend_w0 = v.w0; pend_w1 = v.w1; pend_e = v.e;
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_imm = v.imm; in_valid = 1'b1;
  endtask

  // Called at a falling edge; returns at a falling edge with in_valid low.
  task automatic send(input vec_t v);
    bit acc = 0;
    drive(v);
    for (int c = 0; c < 300; c++) begin
      #1;
      if (in_ready) acc = 1;
      else stall_cnt++;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) chk(0, "accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int c = 0; c < 400; c++) begin
      #2;
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) chk(0, "drain_timeout", exp_q.size(), 32'd0);
    tick();
  endtask

  // Monitor: samples just after the falling edge; inputs are already settled for the next rise.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      prev_stall = 1'b0;
      out_run = 0;
    end else begin
      if (prev_stall) begin
        chk(out_valid == 1'b1, "hold_valid", out_valid, 32'd1);
        chk(out_instr == prev_instr && out_err == prev_err, "hold_word", out_instr, prev_instr);
      end
      if (out_valid && !out_ready) chk(in_ready == 1'b0, "in_ready_stall", in_ready, 32'd0);
      if (!out_valid) chk(in_ready == 1'b1, "in_ready_empty", in_ready, 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_word", out_instr, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(out_instr == e.instr, "word", out_instr, e.instr);
          chk(out_err == e.err, "err_flag", out_err, e.err);
          if (e.err) exp_errcnt++;
        end
        out_run++;
        if (out_run > max_run) max_run = out_run;
      end else begin
        out_run = 0;
      end
      if (in_valid && in_ready) begin
        e.instr = pend_w0; e.err = pend_e;
        exp_q.push_back(e);
        if (pend_n == 2) begin
          e.instr = pend_w1; e.err = 1'b0;
          exp_q.push_back(e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   tbl_err = 0;

    tbl[0]  = mk(3'd0, 7'h13, 5'd5,  5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF, 1, 32'hFFF3_0293, 0, 0);
    tbl[1]  = mk(3'd2, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 32'h0000_0008, 1, 32'h0020_8463, 0, 0);
    tbl[2]  = mk(3'd4, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 1, 32'hFFDF_F0EF, 0, 0);
    tbl[3]  = mk(3'd2, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 32'h0000_0007, 1, 32'h0020_8363, 0, 1);
    tbl[4]  = mk(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF, 2, 32'h1234_6537,
                 32'hFFF5_0513, 0);
    tbl[5]  = mk(3'd5, 7'h00, 5'd1,  5'd0, 5'd0, 3'd0, 32'd100,       1, 32'h0640_0093, 0, 0);
    tbl[6]  = mk(3'd5, 7'h00, 5'd1,  5'd0, 5'd0, 3'd0, 32'h0000_1000, 1, 32'h0000_10B7, 0, 0);
    tbl[7]  = mk(3'd1, 7'h23, 5'd0,  5'd2, 5'd3, 3'd2, 32'hFFFF_FFF8, 1, 32'hFE31_2C23, 0, 0);
    tbl[8]  = mk(3'd3, 7'h37, 5'd3,  5'd0, 5'd0, 3'd0, 32'hABCD_E000, 1, 32'hABCD_E1B7, 0, 0);
    tbl[9]  = mk(3'd3, 7'h37, 5'd3,  5'd0, 5'd0, 3'd0, 32'h0000_1001, 1, 32'h0000_11B7, 0, 1);
    tbl[10] = mk(3'd0, 7'h13, 5'd5,  5'd6, 5'd0, 3'd0, 32'h0000_0800, 1, 32'h8003_0293, 0, 1);
    tbl[11] = mk(3'd0, 7'h13, 5'd5,  5'd6, 5'd0, 3'd0, 32'hFFFF_F800, 1, 32'h8003_0293, 0, 0);
    tbl[12] = mk(3'd6, 7'h33, 5'd7,  5'd1, 5'd2, 3'd1, 32'h0000_0000, 1, 32'h0000_0013, 0, 1);
    tbl[13] = mk(3'd5, 7'h00, 5'd1,  5'd0, 5'd0, 3'd0, 32'h7FFF_F800, 2, 32'h8000_00B7,
                 32'h8000_8093, 0);
    tbl[14] = mk(3'd4, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 32'h0010_0000, 1, 32'h8000_00EF, 0, 1);
    tbl[15] = mk(3'd2, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 32'h0000_1000, 1, 32'h8020_8063, 0, 1);
    tbl[16] = mk(3'd5, 7'h00, 5'd1,  5'd0, 5'd0, 3'd0, 32'hFFFF_F800, 1, 32'h8000_0093, 0, 0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_imm = 32'd0;
    tick();
    tick();
    #2;
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 32'd0);
    chk(out_instr == 32'd0, "rst_out_instr", out_instr, 32'd0);
    chk(out_err == 1'b0, "rst_out_err", out_err, 32'd0);
    chk(err_cnt == 8'd0, "rst_err_cnt", err_cnt, 32'd0);
    chk(busy == 1'b0, "rst_busy", busy, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Vector table, one request at a time.
    rdy_mode = 0;
    foreach (tbl[i]) begin
      send(tbl[i]);
      drain();
      if (tbl[i].e) tbl_err++;
      chk(err_cnt == 8'(tbl_err), "err_cnt_table", err_cnt, tbl_err);
    end

    // Two-word LI with the first word stalled for three cycles.
    rdy_mode = 2; rdy_man = 1'b0; out_ready = 1'b0;
    drive(tbl[4]);
    #2;
    chk(in_ready == 1'b1, "li_accept_ready", in_ready, 32'd1);
    tick();
    in_valid = 1'b0;
    #2;
    chk(out_valid == 1'b1, "li_latency", out_valid, 32'd1);
    chk(out_instr == 32'h1234_6537, "li_lui_word", out_instr, 32'h1234_6537);
    chk(in_ready == 1'b0, "li_lo_in_ready", in_ready, 32'd0);
    chk(busy == 1'b1, "li_busy", busy, 32'd1);
    tick();
    tick();
    #2;
    chk(out_instr == 32'h1234_6537, "li_lui_held", out_instr, 32'h1234_6537);
    rdy_man = 1'b1;
    tick();
    #2;
    chk(in_ready == 1'b0, "li_lo_fire_in_ready", in_ready, 32'd0);
    rdy_man = 1'b0;
    tick();
    #2;
    chk(out_valid == 1'b1, "li_no_bubble", out_valid, 32'd1);
    chk(out_instr == 32'hFFF5_0513, "li_addi_word", out_instr, 32'hFFF5_0513);
    rdy_man = 1'b1;
    tick();
    rdy_mode = 0;
    drain();

    // Throughput: eight back-to-back I requests.
    max_run = 0; stall_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      v = mk(3'd0, 7'h13, 5'(k + 1), 5'(k + 2), 5'd0, 3'(k), 32'(k * 37 - 100), 0, 0, 0, 0);
      model(v);
      send(v);
    end
    drain();
    chk(max_run == 8, "throughput_run", max_run, 32'd8);
    chk(stall_cnt == 0, "throughput_stalls", stall_cnt, 32'd0);

    // Random traffic under random backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      v.fmt = 3'($urandom_range(0, 7));
      v.op  = 7'($urandom); v.rd = 5'($urandom); v.rs1 = 5'($urandom);
      v.rs2 = 5'($urandom); v.f3 = 3'($urandom);
      v.imm = $urandom;
      if ($urandom_range(0, 1) == 1) v.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      if ($urandom_range(0, 3) == 0) v.imm[11:0] = 12'd0;
      model(v);
      send(v);
    end
    drain();
    rdy_mode = 0;
    tick();
    chk(err_cnt == 8'(exp_errcnt), "err_cnt_random", err_cnt, exp_errcnt);

    // Reset while the LI second word is pending.
    rdy_mode = 2; rdy_man = 1'b0; out_ready = 1'b0;
    drive(tbl[4]);
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    chk(busy == 1'b1, "pre_reset_busy", busy, 32'd1);
    chk(err_cnt != 8'd0, "pre_reset_err_cnt", err_cnt, 32'd1);
    tick();
    reset = 1'b1;
    exp_q.delete();
    exp_errcnt = 0;
    #2;
    chk(out_valid == 1'b0, "reset_out_valid", out_valid, 32'd0);
    chk(busy == 1'b0, "reset_busy", busy, 32'd0);
    chk(err_cnt == 8'd0, "reset_err_cnt", err_cnt, 32'd0);
    tick();
    reset = 1'b0;
    rdy_mode = 0;
    tick();
    send(tbl[5]);
    drain();
    repeat (4) tick();
    chk(exp_q.size() == 0 && !out_valid, "post_reset_single", out_valid, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
